// File: rtl/tile_vram_pkg.sv
// Shared types for the tile video RAM: fill-engine state encoding and an
// elaboration-time log2 helper used to validate the address width.
package vram_pkg;

    typedef enum logic [0:0] {
        VR_IDLE  = 1'b0,
        VR_CLEAR = 1'b1
    } vr_state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned bits;
        bits = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << bits) < 64'(value)) begin
                bits = bits + 1;
            end
        end
        return bits;
    endfunction

endpackage

// File: rtl/tile_vram_bank.sv
// Plain inferred dual-port array: synchronous write, registered read that
// returns the pre-write contents on a same-address collision. No reset.
module vram_bank #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned DEPTH  = 375,
    parameter int unsigned ADDR_W = 9
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/tile_vram.sv
// Tile video RAM top: fill-engine FSM, write arbitration (fill wins), address
// range protection and an optional second read pipeline stage.
module tile_vram
    import vram_pkg::*;
#(
    parameter int unsigned       DATA_W       = 4,
    parameter int unsigned       DEPTH        = 375,
    parameter int unsigned       ADDR_W       = 9,
    parameter int unsigned       OUT_REG      = 0,
    parameter int unsigned       CLEAR_ON_RST = 1,
    parameter logic [DATA_W-1:0] FILL_RST     = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              clear_req,
    input  logic [DATA_W-1:0] clear_val,
    output logic              busy,
    output logic              clear_done
);

    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    if (ADDR_W < clog2(DEPTH)) begin : g_bad_addr_w
        $error("tile_vram: ADDR_W too small for DEPTH");
    end

    vr_state_e         state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] fill_val_q, fill_val_d;
    logic              arm_q, arm_d;
    logic              done_q, done_d;
    logic              rd_v1_q, rd_v1_d;
    logic              rd_zero_q, rd_zero_d;

    logic              wr_in_range;
    logic              rd_in_range;
    logic              bank_we;
    logic [ADDR_W-1:0] bank_waddr;
    logic [DATA_W-1:0] bank_wdata;
    logic              bank_re;
    logic [DATA_W-1:0] bank_rdata;
    logic [DATA_W-1:0] s1_data;

    assign busy        = (state_q == VR_CLEAR);
    assign wr_ready    = !busy;
    assign clear_done  = done_q;
    assign wr_in_range = {1'b0, wr_addr} < DEPTH_X;
    assign rd_in_range = {1'b0, rd_addr} < DEPTH_X;

    // arm_q stands in for a clear request on the first cycle out of reset,
    // so the reset-triggered fill follows the same path as clear_req.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        fill_val_d = fill_val_q;
        arm_d      = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            VR_IDLE: begin
                if (arm_q) begin
                    state_d    = VR_CLEAR;
                    cnt_d      = '0;
                    fill_val_d = FILL_RST;
                end else if (clear_req) begin
                    state_d    = VR_CLEAR;
                    cnt_d      = '0;
                    fill_val_d = clear_val;
                end
            end
            VR_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = VR_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = VR_IDLE;
        endcase
    end

    always_comb begin
        rd_v1_d   = rd_en;
        rd_zero_d = rd_en ? !rd_in_range : rd_zero_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= VR_IDLE;
            cnt_q      <= '0;
            fill_val_q <= FILL_RST;
            arm_q      <= (CLEAR_ON_RST != 0);
            done_q     <= 1'b0;
            rd_v1_q    <= 1'b0;
            rd_zero_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            fill_val_q <= fill_val_d;
            arm_q      <= arm_d;
            done_q     <= done_d;
            rd_v1_q    <= rd_v1_d;
            rd_zero_q  <= rd_zero_d;
        end
    end

    // Writes are gated by rst so an aborted fill leaves the current word intact.
    assign bank_we    = !rst && (busy || (wr_en && wr_in_range));
    assign bank_waddr = busy ? cnt_q : wr_addr;
    assign bank_wdata = busy ? fill_val_q : wr_data;
    assign bank_re    = rd_en && rd_in_range;

    vram_bank #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_bank (
        .clk   (clk),
        .we    (bank_we),
        .waddr (bank_waddr),
        .wdata (bank_wdata),
        .re    (bank_re),
        .raddr (rd_addr),
        .rdata (bank_rdata)
    );

    assign s1_data = rd_zero_q ? '0 : bank_rdata;

    if (OUT_REG != 0) begin : g_out_reg
        logic              rd_v2_q, rd_v2_d;
        logic [DATA_W-1:0] rd_d2_q, rd_d2_d;

        always_comb begin
            rd_v2_d = rd_v1_q;
            rd_d2_d = rd_v1_q ? s1_data : rd_d2_q;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                rd_v2_q <= 1'b0;
                rd_d2_q <= '0;
            end else begin
                rd_v2_q <= rd_v2_d;
                rd_d2_q <= rd_d2_d;
            end
        end

        assign rd_valid = rd_v2_q;
        assign rd_data  = rd_d2_q;
    end else begin : g_no_out_reg
        assign rd_valid = rd_v1_q;
        assign rd_data  = s1_data;
    end

endmodule

// File: doc/tile_vram.md
# tile_vram

Parametrised single-clock tile video RAM for the game display path. The game logic writes tile codes on one port while the VGA scanner reads them on the other. It adds four things the fixed 375x4 dual-port RAM lacks: configurable geometry, an optional output register, address-range protection, and a hardware fill engine that clears the whole playfield in DEPTH cycles (optionally on reset).

## Interface
- DATA_W, default 4: tile code width in bits.
- DEPTH, default 375: number of words (playfield cells), 2..4096.
- ADDR_W, default 9: address width; requires 2**ADDR_W >= DEPTH.
- OUT_REG, default 0: 0 gives read latency 1; 1 adds an output register, giving latency 2.
- CLEAR_ON_RST, default 1: 1 starts a fill with FILL_RST automatically when reset is released.
- FILL_RST, default 0: fill value used by the reset-triggered clear.
- clk, input, 1: single clock for both ports.
- rst, input, 1: synchronous, active-high reset.
- wr_en, input, 1: write request.
- wr_addr, input, ADDR_W: write address.
- wr_data, input, DATA_W: write data.
- wr_ready, output, 1: high when a write is accepted; equals !busy.
- rd_en, input, 1: read request.
- rd_addr, input, ADDR_W: read address.
- rd_data, output, DATA_W: read data.
- rd_valid, output, 1: rd_data is valid this cycle.
- clear_req, input, 1: single-cycle request to fill all words.
- clear_val, input, DATA_W: fill value, sampled when clear_req is accepted.
- busy, output, 1: fill in progress.
- clear_done, output, 1: one-cycle pulse when a fill completes.

## Operation
- FSM states are IDLE and CLEAR.
- IDLE to CLEAR on clear_req, or on the first cycle after rst deasserts when CLEAR_ON_RST=1. On entry: fill counter = 0 and fill value is latched.
- CLEAR writes the latched value to the counter address, one word per cycle, then increments the counter.
  - After writing address DEPTH-1, return to IDLE and pulse clear_done.
- clear_req is ignored while busy; there is no restart.
- External writes:
  - Committed only when wr_en && wr_ready && wr_addr < DEPTH.
  - A write with wr_addr >= DEPTH is dropped silently.
  - A write while busy is dropped; the caller must hold wr_en until wr_ready is high.
- wr_en and clear_req in the same IDLE cycle: the write commits that cycle, and the clear starts next cycle and overwrites it.
- Reads are permitted in every state.
  - rd_addr >= DEPTH returns 0 with rd_valid still asserted.
  - During CLEAR a read returns the current array contents, which may be partly filled.
- A read and write to the same address in the same cycle returns the old data (read-before-write). This also applies to fill-engine writes.
- rst does not erase array contents. It aborts any fill in progress, which stays partial unless CLEAR_ON_RST=1.

## Timing
- Reset values: rd_data=0, rd_valid=0, busy=0, clear_done=0, wr_ready=1.
  - Exception: with CLEAR_ON_RST=1, busy=1 and wr_ready=0 from the first cycle after rst deasserts.
- Read latency from the rd_en cycle to the rd_valid cycle is 1+OUT_REG clocks. rd_data holds its value when rd_en is low.
- busy rises the cycle after clear_req is accepted, stays high for exactly DEPTH cycles, and falls in the same cycle clear_done pulses.
- A full fill takes DEPTH cycles; the first external write can be accepted in the cycle clear_done is high.
- A write is visible to a read issued in the following cycle.

## Structure
- Package vram_pkg holds the FSM state enum (VR_IDLE, VR_CLEAR) and a function clog2 for checking ADDR_W.
- Sub-module vram_bank is a simple inferred dual-port array: synchronous write, registered read-before-write, no reset. It is the only place memory is inferred, so the tool can map it to block RAM.
- The top level holds the FSM, fill counter, write mux (fill engine has priority), range checks and optional output register.

## Test plan
- Reset with CLEAR_ON_RST=1, FILL_RST=0 -> busy for 375 cycles, one clear_done pulse, then all 375 reads return 0.
- Write 0xA to address 10, read address 10 next cycle -> rd_data=0xA with latency 1 (OUT_REG=0) or 2 (OUT_REG=1).
- Same-cycle read and write of 0x5 to address 20, which holds 0x3 -> read returns 0x3; the following read returns 0x5.
- Write 0xF to address 400 -> dropped; a read of address 400 returns 0 with rd_valid=1, and address 400 mod 512 is unaffected.
- clear_req with clear_val=0x7 plus wr_en to address 0 during CLEAR -> wr_ready=0 and the write is dropped; afterwards address 0 reads 0x7. A second clear_req mid-fill is ignored.
- Assert rst at fill counter 100 with CLEAR_ON_RST=0 -> busy=0 next cycle, no clear_done pulse, addresses 100..374 keep their old values.
